ball_paddle_referee: RTL and testbench

//  Downstream of paddle: once per frame, compares the paddle box (paddleX/Y/S) with the ball box.

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/range_overlap.sv | 14 +
 rtl/ball_paddle_referee.sv | 167 ++++++++++++++++
 tb/tb_ball_paddle_referee.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types, constants and edge/score helpers for the pong referee.
// Score encoding is selected by SCORE_BCD_EN (packed BCD when defined, binary otherwise).
package pong_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [10:0] wide_t;

  typedef enum logic [2:0] {
    SERVE,
    PLAY,
    SAMPLE,
    EVAL,
    RESOLVE,
    OVER
  } ref_state_t;

  localparam logic [7:0] SCORE_MAX_BIN = 8'hFF;
  localparam logic [7:0] SCORE_MAX_BCD = 8'h99;

  // Lower edge of a centred box, clamped at 0 rather than wrapping.
  function automatic wide_t lo_edge(input coord_t c, input coord_t s);
    return (c > s) ? ({1'b0, c} - {1'b0, s}) : '0;
  endfunction

  function automatic wide_t hi_edge(input coord_t c, input coord_t s);
    return {1'b0, c} + {1'b0, s};
  endfunction

  function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
    if (s == SCORE_MAX_BCD) return s;
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
`else
    if (s == SCORE_MAX_BIN) return s;
    return s + 8'd1;
`endif
  endfunction

endpackage

// File: rtl/range_overlap.sv
// Combinational 1-D closed-interval overlap test: [lo_a,hi_a] intersects [lo_b,hi_b].
module range_overlap
  import pong_pkg::*;
(
  input  wide_t lo_a,
  input  wide_t hi_a,
  input  wide_t lo_b,
  input  wide_t hi_b,
  output logic  ov
);

  assign ov = (lo_a <= hi_b) && (hi_a >= lo_b);

endmodule

// File: rtl/ball_paddle_referee.sv
// Per-frame ball/paddle referee: hit/miss strobes, score, lives and serve/game-over FSM.
// Define SCORE_BCD_EN for a two-digit packed-BCD score (saturating at 99); binary otherwise.
module ball_paddle_referee
  import pong_pkg::*;
#(
  parameter coord_t     PADDLE_W     = 10'd8,
  parameter coord_t     MISS_X       = 10'd4,
  parameter logic [3:0] START_LIVES  = 4'd3,
  parameter logic [3:0] HIT_COOLDOWN = 4'd8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [9:0] paddleX,
  input  logic [9:0] paddleY,
  input  logic [9:0] paddleS,
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic [9:0] ballS,
  input  logic       serve_req,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       ball_release,
  output logic [7:0] score,
  output logic [3:0] lives,
  output logic       in_play,
  output logic       game_over
);

  ref_state_t state_reg, state_next;

  coord_t px_reg, py_reg, ps_reg, bx_reg, by_reg, bs_reg;
  logic       xov_reg, yov_reg, edge_reg;
  logic       hit_reg, miss_reg, release_reg;
  logic       serve_prev_reg;
  logic [3:0] cooldown_reg;
  logic [7:0] score_reg;
  logic [3:0] lives_reg;

  // Index 0 is the x axis, index 1 the y axis; operand a is the ball, b the paddle.
  wide_t lo_a [2];
  wide_t hi_a [2];
  wide_t lo_b [2];
  wide_t hi_b [2];
  logic [1:0] ov;

  assign lo_a[0] = lo_edge(bx_reg, bs_reg);
  assign hi_a[0] = hi_edge(bx_reg, bs_reg);
  assign lo_b[0] = {1'b0, px_reg};
  assign hi_b[0] = {1'b0, px_reg} + {1'b0, PADDLE_W};
  assign lo_a[1] = lo_edge(by_reg, bs_reg);
  assign hi_a[1] = hi_edge(by_reg, bs_reg);
  assign lo_b[1] = lo_edge(py_reg, ps_reg);
  assign hi_b[1] = hi_edge(py_reg, ps_reg);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      range_overlap u_ov (
        .lo_a (lo_a[gi]),
        .hi_a (hi_a[gi]),
        .lo_b (lo_b[gi]),
        .hi_b (hi_b[gi]),
        .ov   (ov[gi])
      );
    end
  endgenerate

  logic serve_rise;
  logic hit_now;
  logic miss_now;

  assign serve_rise = serve_req && !serve_prev_reg;
  // A hit always takes precedence over a miss in the same frame.
  assign hit_now    = xov_reg && yov_reg && (cooldown_reg == 4'd0);
  assign miss_now   = edge_reg && !hit_now;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SERVE:   if (serve_req) state_next = PLAY;
      PLAY:    if (frame_start) state_next = SAMPLE;
      SAMPLE:  state_next = EVAL;
      EVAL:    state_next = RESOLVE;
      RESOLVE: begin
        if (miss_reg) state_next = (lives_reg == 4'd0) ? OVER : SERVE;
        else          state_next = PLAY;
      end
      OVER:    if (serve_rise) state_next = SERVE;
      default: state_next = SERVE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) state_reg <= SERVE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      px_reg         <= '0;
      py_reg         <= '0;
      ps_reg         <= '0;
      bx_reg         <= '0;
      by_reg         <= '0;
      bs_reg         <= '0;
      xov_reg        <= 1'b0;
      yov_reg        <= 1'b0;
      edge_reg       <= 1'b0;
      hit_reg        <= 1'b0;
      miss_reg       <= 1'b0;
      release_reg    <= 1'b0;
      serve_prev_reg <= 1'b0;
      cooldown_reg   <= 4'd0;
      score_reg      <= 8'd0;
      lives_reg      <= START_LIVES;
    end else begin
      hit_reg        <= 1'b0;
      miss_reg       <= 1'b0;
      release_reg    <= 1'b0;
      serve_prev_reg <= serve_req;
      case (state_reg)
        SERVE: if (serve_req) release_reg <= 1'b1;
        PLAY: begin
          if (frame_start) begin
            px_reg <= paddleX;
            py_reg <= paddleY;
            ps_reg <= paddleS;
            bx_reg <= ballX;
            by_reg <= ballY;
            bs_reg <= ballS;
            if (cooldown_reg != 4'd0) cooldown_reg <= cooldown_reg - 4'd1;
          end
        end
        SAMPLE: begin
          xov_reg  <= ov[0];
          yov_reg  <= ov[1];
          edge_reg <= (lo_a[0] <= {1'b0, MISS_X});
        end
        EVAL: begin
          hit_reg  <= hit_now;
          miss_reg <= miss_now;
          if (hit_now) begin
            score_reg    <= score_inc(score_reg);
            cooldown_reg <= HIT_COOLDOWN;
          end
          if (miss_now && lives_reg != 4'd0) lives_reg <= lives_reg - 4'd1;
        end
        OVER: begin
          if (serve_rise) begin
            score_reg <= 8'd0;
            lives_reg <= START_LIVES;
          end
        end
        default: ;
      endcase
    end
  end

  assign hit_pulse    = hit_reg;
  assign miss_pulse   = miss_reg;
  assign ball_release = release_reg;
  assign score        = score_reg;
  assign lives        = lives_reg;
  assign in_play      = (state_reg == PLAY);
  assign game_over    = (state_reg == OVER);

endmodule

// File: tb/tb_ball_paddle_referee.sv
// Directed plus randomized bench for ball_paddle_referee against a frame-level reference model.
module tb_ball_paddle_referee;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] paddleX = '0, paddleY = '0, paddleS = '0;
  logic [9:0] ballX = '0, ballY = '0, ballS = '0;
  logic       serve_req = 1'b0;
  logic       hit_pulse, miss_pulse, ball_release;
  logic [7:0] score;
  logic [3:0] lives;
  logic       in_play, game_over;

  ball_paddle_referee dut (
    .vga_clk      (vga_clk),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .paddleX      (paddleX),
    .paddleY      (paddleY),
    .paddleS      (paddleS),
    .ballX        (ballX),
    .ballY        (ballY),
    .ballS        (ballS),
    .serve_req    (serve_req),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .ball_release (ball_release),
    .score        (score),
    .lives        (lives),
    .in_play      (in_play),
    .game_over    (game_over)
  );

  always #5 vga_clk = ~vga_clk;

`ifdef SCORE_BCD_EN
  localparam int SAT = 99;
`else
  localparam int SAT = 255;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: mode 0=serving, 1=playing, 2=game over.
  int m_mode, m_lives, m_hits, m_cd;

  function automatic int exp_score();
    int h;
    h = (m_hits > SAT) ? SAT : m_hits;
`ifdef SCORE_BCD_EN
    return ((h / 10) << 4) | (h % 10);
`else
    return h;
`endif
  endfunction

  function automatic int lo(input int c, input int s);
    return (c > s) ? c - s : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_score"}, score, exp_score());
    check({tag, "_lives"}, lives, m_lives);
    check({tag, "_in_play"}, in_play, m_mode == 1);
    check({tag, "_game_over"}, game_over, m_mode == 2);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_mode = 0; m_lives = 3; m_hits = 0; m_cd = 0;
    check("rst_hit", hit_pulse, 0);
    check("rst_miss", miss_pulse, 0);
    check("rst_release", ball_release, 0);
    check_status("rst");
  endtask

  task automatic serve();
    bit exp_rel;
    serve_req = 1'b1;
    tick();
    serve_req = 1'b0;
    exp_rel = 0;
    if (m_mode == 0) begin
      m_mode = 1;
      exp_rel = 1;
    end else if (m_mode == 2) begin
      m_mode = 0; m_lives = 3; m_hits = 0;
    end
    $display("serve: release=%0b in_play=%0b lives=%0d score=%0h", ball_release, in_play, lives, score);
    check("serve_release", ball_release, exp_rel);
    check_status("serve");
    tick();
    check("release_once", ball_release, 0);
  endtask

  task automatic frame(input int px, input int py, input int ps,
                       input int bx, input int by, input int bs, input bit hold_serve);
    bit e_hit, e_miss, xov, yov;
    paddleX = px[9:0]; paddleY = py[9:0]; paddleS = ps[9:0];
    ballX = bx[9:0]; ballY = by[9:0]; ballS = bs[9:0];
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    e_hit = 0; e_miss = 0;
    if (m_mode == 1) begin
      if (m_cd > 0) m_cd--;
      xov = (lo(bx, bs) <= px + 8) && (bx + bs >= px);
      yov = (by + bs >= lo(py, ps)) && (lo(by, bs) <= py + ps);
      e_hit = xov && yov && (m_cd == 0);
      e_miss = (lo(bx, bs) <= 4) && !e_hit;
    end
    tick();
    check("no_early_strobe", {hit_pulse, miss_pulse}, 0);
    tick();
    if (e_hit) begin
      m_hits++;
      m_cd = 8;
    end
    if (e_miss) m_lives--;
    $display("frame p(%0d,%0d,%0d) b(%0d,%0d,%0d): hit=%0b miss=%0b score=%0h lives=%0d",
             px, py, ps, bx, by, bs, hit_pulse, miss_pulse, score, lives);
    check("hit_pulse", hit_pulse, e_hit);
    check("miss_pulse", miss_pulse, e_miss);
    check("frame_score", score, exp_score());
    check("frame_lives", lives, m_lives);
    if (hold_serve) serve_req = 1'b1;
    tick();
    if (e_miss) m_mode = (m_lives == 0) ? 2 : 0;
    check("strobe_one_cycle", {hit_pulse, miss_pulse}, 0);
    check_status("after_frame");
  endtask

  initial begin
    m_mode = 0; m_lives = 3; m_hits = 0; m_cd = 0;
    tick();
    do_reset();

    // frame_start while serving is ignored
    frame(20, 240, 80, 30, 200, 4, 0);
    serve();

    // single hit, then cooldown suppresses frames 2..8, frame 9 hits again
    frame(20, 240, 80, 30, 200, 4, 0);
    check("first_hit_score", score, 1);
    for (int i = 0; i < 8; i++) frame(20, 240, 80, 30, 200, 4, 0);
    check("ninth_hit_score", score, 2);

    // three misses end the game; held serve_req must not restart
    frame(20, 240, 80, 3, 20, 4, 0);
    check("miss1_lives", lives, 2);
    serve();
    frame(20, 240, 80, 3, 20, 4, 0);
    serve();
    frame(20, 240, 80, 3, 20, 4, 1);
    check("over_lives", lives, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_serve_no_restart", game_over, 1);
    end
    serve_req = 1'b0;
    tick();
    serve();
    check("restart_lives", lives, 3);
    serve();

    // hit wins over miss
    for (int i = 0; i < 12 && m_cd > 0; i++) frame(20, 240, 80, 200, 200, 4, 0);
    frame(0, 240, 80, 6, 160, 4, 0);
    check("hit_over_miss", score, exp_score());

    // randomized frames and serves
    for (int i = 0; i < 120; i++) begin
      if (m_mode != 1) serve();
      else frame($urandom_range(40, 0), $urandom_range(440, 40), $urandom_range(80, 5),
                 $urandom_range(60, 0), $urandom_range(479, 0), $urandom_range(12, 0), 0);
    end

    // reset the cycle after frame_start aborts the evaluation
    do_reset();
    serve();
    paddleX = 10'd20; paddleY = 10'd240; paddleS = 10'd80;
    ballX = 10'd30; ballY = 10'd200; ballS = 10'd4;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_mode = 0; m_lives = 3; m_hits = 0; m_cd = 0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_strobe", {hit_pulse, miss_pulse}, 0);
      check_status("abort");
      tick();
    end

    // score saturation
    serve();
    for (int i = 0; i < 4000 && m_hits < SAT + 3; i++) frame(20, 240, 80, 30, 200, 4, 0);
    check("score_saturated", score, SAT == 99 ? 8'h99 : 8'hFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
